// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the March C- RAM self-test controller.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_M0     = 3'd1,
    S_M1     = 3'd2,
    S_M2     = 3'd3,
    S_M3     = 3'd4,
    S_FINISH = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Background fill bits; replicate to the RAM width at the point of use.
  localparam logic BG0 = 1'b0;
  localparam logic BG1 = 1'b1;

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data compare pipeline: holds the expectation for the read in flight,
// counts mismatches and captures the address of the first one.
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDRESS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               rd_issue,
  input  logic [ADDRESS-1:0] rd_addr,
  input  logic [WIDTH-1:0]   rd_exp,
  input  logic [WIDTH-1:0]   rd_data,
  output logic [ADDRESS+1:0] err_count,
  output logic [ADDRESS-1:0] fail_addr
);

  localparam int ERR_W = ADDRESS + 2;

  logic               cmp_vld_q, cmp_vld_d;
  logic [ADDRESS-1:0] cmp_addr_q, cmp_addr_d;
  logic [WIDTH-1:0]   cmp_exp_q, cmp_exp_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [ADDRESS-1:0] fail_addr_q, fail_addr_d;
  logic               first_seen_q, first_seen_d;
  logic               mismatch;

  always_comb begin
    cmp_vld_d    = rd_issue;
    cmp_addr_d   = rd_addr;
    cmp_exp_d    = rd_exp;
    err_count_d  = err_count_q;
    fail_addr_d  = fail_addr_q;
    first_seen_d = first_seen_q;
    mismatch     = cmp_vld_q && (rd_data != cmp_exp_q);
    if (clear) begin
      err_count_d  = '0;
      fail_addr_d  = '0;
      first_seen_d = 1'b0;
    end else if (mismatch) begin
      if (err_count_q != {ERR_W{1'b1}}) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
      if (!first_seen_q) begin
        fail_addr_d  = cmp_addr_q;
        first_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmp_vld_q    <= 1'b0;
      cmp_addr_q   <= '0;
      cmp_exp_q    <= '0;
      err_count_q  <= '0;
      fail_addr_q  <= '0;
      first_seen_q <= 1'b0;
    end else begin
      cmp_vld_q    <= cmp_vld_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_exp_q    <= cmp_exp_d;
      err_count_q  <= err_count_d;
      fail_addr_q  <= fail_addr_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: rtl/ram_bist.sv
// March C- self-test controller: drives the RAM port through four elements
// and reports pass/fail, error count and first failing address.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int ADDRESS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDRESS+1:0] err_count,
  output logic [ADDRESS-1:0] fail_addr,
  output logic               wr_enb,
  output logic [ADDRESS-1:0] wr_addr,
  output logic [WIDTH-1:0]   wr_data,
  output logic               rd_enb,
  output logic [ADDRESS-1:0] rd_addr,
  input  logic [WIDTH-1:0]   rd_data
);

  localparam logic [ADDRESS-1:0] LAST_ADDR = ADDRESS'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDRESS-1:0] addr_q, addr_d;
  logic               pass_q, pass_d;
  logic               clear;
  logic [WIDTH-1:0]   rd_exp;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_M0;
          addr_d  = '0;
          pass_d  = 1'b0;
          clear   = 1'b1;
        end
      end
      S_M0: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDRESS'(1);
        end
      end
      S_M1: begin
        // M2 walks downwards, so it starts from the top address.
        if (addr_q == LAST_ADDR) begin
          state_d = S_M2;
          addr_d  = LAST_ADDR;
        end else begin
          addr_d = addr_q + ADDRESS'(1);
        end
      end
      S_M2: begin
        if (addr_q == '0) begin
          state_d = S_M3;
          addr_d  = '0;
        end else begin
          addr_d = addr_q - ADDRESS'(1);
        end
      end
      S_M3: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_FINISH;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDRESS'(1);
        end
      end
      S_FINISH: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        pass_d  = (err_count == '0);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM port decode; M1/M2 read and write the same word in one cycle.
  always_comb begin
    wr_enb  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_enb  = 1'b0;
    rd_addr = '0;
    rd_exp  = '0;
    case (state_q)
      S_M0: begin
        wr_enb  = 1'b1;
        wr_addr = addr_q;
        wr_data = {WIDTH{BG0}};
      end
      S_M1: begin
        rd_enb  = 1'b1;
        rd_addr = addr_q;
        rd_exp  = {WIDTH{BG0}};
        wr_enb  = 1'b1;
        wr_addr = addr_q;
        wr_data = {WIDTH{BG1}};
      end
      S_M2: begin
        rd_enb  = 1'b1;
        rd_addr = addr_q;
        rd_exp  = {WIDTH{BG1}};
        wr_enb  = 1'b1;
        wr_addr = addr_q;
        wr_data = {WIDTH{BG0}};
      end
      S_M3: begin
        rd_enb  = 1'b1;
        rd_addr = addr_q;
        rd_exp  = {WIDTH{BG0}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
    end
  end

  ram_bist_cmp #(
    .WIDTH  (WIDTH),
    .ADDRESS(ADDRESS)
  ) u_cmp (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .rd_issue (rd_enb),
    .rd_addr  (rd_addr),
    .rd_exp   (rd_exp),
    .rd_data  (rd_data),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  // The final count is already settled in DONE, so pass is valid alongside done.
  assign pass = pass_q | (done && (err_count == '0));

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist with a fault-injecting read-before-write RAM.
module tb_ram_bist;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 16;
  localparam int ADDRESS    = 4;
  localparam int RUN_CYCLES = 4 * DEPTH + 2;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               busy, done, pass;
  logic [ADDRESS+1:0] err_count;
  logic [ADDRESS-1:0] fail_addr;
  logic               wr_enb, rd_enb;
  logic [ADDRESS-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   rd_data = '0;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] sa1_mask [DEPTH];
  logic [WIDTH-1:0] sa0_mask [DEPTH];

  always #5 clock = ~clock;

  ram_bist #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDRESS(ADDRESS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .wr_enb   (wr_enb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_enb   (rd_enb),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  function automatic logic [WIDTH-1:0] stored(input logic [WIDTH-1:0] w, input int a);
    return (w | sa1_mask[a]) & ~sa0_mask[a];
  endfunction

  // Registered-read RAM; a simultaneous read returns the old word.
  always @(posedge clock) begin
    if (wr_enb) mem[wr_addr] <= stored(wr_data, int'(wr_addr));
    if (rd_enb) rd_data <= mem[rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-run abstract March C- walk over the faulty memory.
  function automatic void march_model(output int n_err, output int first);
    logic [WIDTH-1:0] m [DEPTH];
    logic [WIDTH-1:0] zero;
    logic [WIDTH-1:0] ones;
    zero  = '0;
    ones  = '1;
    n_err = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) m[a] = stored(zero, a);
    for (int a = 0; a < DEPTH; a++) begin
      if (m[a] !== zero) begin if (n_err == 0) first = a; n_err++; end
      m[a] = stored(ones, a);
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      if (m[a] !== ones) begin if (n_err == 0) first = a; n_err++; end
      m[a] = stored(zero, a);
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (m[a] !== zero) begin if (n_err == 0) first = a; n_err++; end
    end
  endfunction

  // Per-cycle checker driven by the cycle offset since start acceptance.
  logic start_s = 1'b0;
  logic reset_s = 1'b1;
  bit   chk_en  = 1'b0;
  int   t = -1;
  int   exp_err = 0, exp_fail = 0;
  int   hold_err = 0, hold_fail = 0;
  logic hold_pass = 1'b0;
  int   m_e, m_i, m_a;
  logic x_busy, x_done, x_wen, x_ren;
  logic [ADDRESS-1:0] x_wa, x_ra;
  logic [WIDTH-1:0]   x_wd;

  always @(posedge clock) begin
    start_s <= start;
    reset_s <= reset;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      if (reset_s) begin
        t = -1; hold_err = 0; hold_fail = 0; hold_pass = 1'b0;
      end else if (t < 0) begin
        if (start_s) begin
          t = 1;
          march_model(exp_err, exp_fail);
        end
      end else if (t == RUN_CYCLES) begin
        t = -1; hold_err = exp_err; hold_fail = exp_fail; hold_pass = (exp_err == 0);
      end else begin
        t++;
      end

      x_busy = (t >= 1) && (t <= 4 * DEPTH + 1);
      x_done = (t == RUN_CYCLES);
      x_wen = 1'b0; x_ren = 1'b0; x_wa = '0; x_ra = '0; x_wd = '0;
      if (t >= 1 && t <= 4 * DEPTH) begin
        m_e = (t - 1) / DEPTH;
        m_i = (t - 1) % DEPTH;
        m_a = (m_e == 2) ? DEPTH - 1 - m_i : m_i;
        x_wen = (m_e != 3);
        x_ren = (m_e != 0);
        x_wd  = (m_e == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        x_wa  = x_wen ? ADDRESS'(m_a) : '0;
        x_ra  = x_ren ? ADDRESS'(m_a) : '0;
      end
      check("cyc_busy", 32'(busy), 32'(x_busy));
      check("cyc_done", 32'(done), 32'(x_done));
      check("cyc_wr_enb", 32'(wr_enb), 32'(x_wen));
      check("cyc_wr_addr", 32'(wr_addr), 32'(x_wa));
      check("cyc_wr_data", 32'(wr_data), 32'(x_wd));
      check("cyc_rd_enb", 32'(rd_enb), 32'(x_ren));
      check("cyc_rd_addr", 32'(rd_addr), 32'(x_ra));
      if (t == 1) begin
        check("start_err_clear", 32'(err_count), 32'd0);
        check("start_fail_clear", 32'(fail_addr), 32'd0);
      end
      if (t >= 1 && t < RUN_CYCLES) check("run_pass_low", 32'(pass), 32'd0);
      if (t == RUN_CYCLES) begin
        check("done_err_count", 32'(err_count), 32'(exp_err));
        check("done_fail_addr", 32'(fail_addr), 32'(exp_fail));
        check("done_pass", 32'(pass), 32'(exp_err == 0));
      end
      if (t < 0) begin
        check("idle_err_count", 32'(err_count), 32'(hold_err));
        check("idle_fail_addr", 32'(fail_addr), 32'(hold_fail));
        check("idle_pass", 32'(pass), 32'(hold_pass));
      end
    end
  end

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      sa1_mask[a] = '0;
      sa0_mask[a] = '0;
    end
  endtask

  task automatic pin_model(input string name, input int lit_err, input int lit_fail);
    int me, mf;
    march_model(me, mf);
    check({name, "_model_err"}, 32'(me), 32'(lit_err));
    check({name, "_model_fail"}, 32'(mf), 32'(lit_fail));
  endtask

  // One start pulse; optional second pulse at cycle pulse_at while busy.
  task automatic run_once(input string name, input int lit_err, input int lit_fail,
                          input int lit_pass, input int pulse_at);
    int k;
    bit got;
    @(negedge clock);
    start = 1'b1;
    k = 0;
    got = 1'b0;
    while (k < 200 && !got) begin
      @(negedge clock);
      k++;
      if (k == 1) start = 1'b0;
      if (pulse_at > 0 && k == pulse_at) start = 1'b1;
      if (pulse_at > 0 && k == pulse_at + 1) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_done_cycle"}, 32'(k), 32'd66);
    check({name, "_err_count"}, 32'(err_count), 32'(lit_err));
    check({name, "_fail_addr"}, 32'(fail_addr), 32'(lit_fail));
    check({name, "_pass"}, 32'(pass), 32'(lit_pass));
    $display("run %s: done after %0d cycles err_count %0d fail_addr %0d pass %0d",
             name, k, err_count, fail_addr, pass);
  endtask

  initial begin
    int k, dones, first_k, second_k;
    bit saw_done;
    clear_faults();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_fail_addr", 32'(fail_addr), 32'd0);
    check("rst_ram_port", 32'({wr_enb, rd_enb, wr_addr, rd_addr, wr_data}), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    pin_model("clean", 0, 0);
    run_once("clean", 0, 0, 1, 0);

    sa1_mask[5] = 8'h01;
    pin_model("sa1_a5", 2, 5);
    run_once("sa1_a5", 2, 5, 0, 0);
    clear_faults();

    sa0_mask[9] = 8'h80;
    pin_model("sa0_a9", 1, 9);
    run_once("sa0_a9", 1, 9, 0, 0);
    clear_faults();

    sa0_mask[3]  = 8'h80;
    sa0_mask[12] = 8'h80;
    pin_model("sa0_a3_a12", 2, 12);
    run_once("sa0_a3_a12", 2, 12, 0, 0);
    clear_faults();

    // Reset in cycle 30 (mid-M1) aborts the run without a done pulse.
    @(negedge clock);
    start = 1'b1;
    k = 0;
    saw_done = 1'b0;
    while (k < 100) begin
      @(negedge clock);
      k++;
      if (k == 1) start = 1'b0;
      if (k == 30) reset = 1'b1;
      if (k == 31) begin
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wr_enb", 32'(wr_enb), 32'd0);
        check("abort_rd_enb", 32'(rd_enb), 32'd0);
        reset = 1'b0;
      end
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    $display("run abort: reset at cycle 30, done seen %0d", saw_done);
    run_once("after_abort", 0, 0, 1, 0);

    run_once("pulse_in_m2", 0, 0, 1, 40);

    // Start held high: two back-to-back runs one IDLE cycle apart.
    sa1_mask[5] = 8'h01;
    @(negedge clock);
    start = 1'b1;
    k = 0;
    dones = 0;
    first_k = 0;
    second_k = 0;
    while (k < 300 && dones < 2) begin
      @(negedge clock);
      k++;
      if (done) begin
        dones++;
        if (dones == 1) first_k = k;
        else begin
          second_k = k;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(dones), 32'd2);
    check("held_first_done", 32'(first_k), 32'd66);
    check("held_second_done", 32'(second_k), 32'd133);
    check("held_err_count", 32'(err_count), 32'd2);
    $display("run held_start: done at cycles %0d and %0d err_count %0d", first_k, second_k, err_count);
    clear_faults();
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test controller that acts as the initiator on the single-clock dual-port RAM's write/read interface. It runs a four-element March C- style test over every address, checks read data returned with the RAM's one-cycle registered read latency, and reports pass/fail, error count and first failing address. It sits beside each RAM instance and owns the RAM's port while busy; normal traffic is muxed in by the parent when `busy` is low.

## Interface
- `WIDTH`, 8: RAM data width.
- `DEPTH`, 16: RAM word count; must equal 2**ADDRESS.
- `ADDRESS`, 4: RAM address width.

- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin test; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start acceptance until done.
- `done`  out  1  one-cycle pulse at test end.
- `pass`  out  1  valid with done, held until next start; high iff err_count==0.
- `err_count`  out  ADDRESS+2  number of read mismatches in the current/last run.
- `fail_addr`  out  ADDRESS  address of the first mismatch; 0 if none.
- `wr_enb`  out  1  RAM write enable.
- `wr_addr`  out  ADDRESS  RAM write address.
- `wr_data`  out  WIDTH  RAM write data.
- `rd_enb`  out  1  RAM read enable.
- `rd_addr`  out  ADDRESS  RAM read address.
- `rd_data`  in  WIDTH  RAM registered read data.

## Operation
- States: IDLE, M0, M1, M2, M3, FINISH, DONE.
- IDLE: `start` high → M0; clear err_count, fail_addr, pass, first-fail flag; addr counter ← 0.
- M0 (ascending): write all-zeros; no read.
- M1 (ascending): read expect all-zeros, write all-ones, same address, same cycle.
- M2 (descending, DEPTH-1 → 0): read expect all-ones, write all-zeros.
- M3 (ascending): read expect all-zeros; no write.
- Each element spends one cycle per address; transition on the last address (DEPTH-1 ascending, 0 descending); counter reloads to the next element's start address.
- Read and write to the same address in one cycle return old data (RAM read-before-write); M1/M2 expected values depend on this.
- Compare pipeline: on a read-issue cycle register cmp_vld, cmp_addr, cmp_exp; the next cycle compare `rd_data` to cmp_exp. On mismatch, err_count +1 (saturating at all-ones); if first mismatch, capture fail_addr.
- FINISH: no RAM access; resolves the last M3 compare.
- DONE: `done`=1, `pass` updated, → IDLE.
- `start` while busy: ignored. `start` held high in IDLE after DONE starts a new run.
- RAM-side outputs decode from registered state/counter; all zero in IDLE, FINISH, DONE.

## Timing
- Reset: state IDLE; busy, done, pass, err_count, fail_addr, wr_enb, rd_enb, wr_addr, rd_addr, wr_data all 0; compare pipeline invalid.
- Reset mid-test: abort immediately, no done pulse, outputs as above next cycle.
- Start sampled at edge ending cycle N: M0 cycles N+1..N+DEPTH; M1 N+DEPTH+1..N+2·DEPTH; M2 next DEPTH; M3 next DEPTH; FINISH N+4·DEPTH+1; done pulse cycle N+4·DEPTH+2 (DEPTH=16: 66 cycles after start).
- Read issued cycle k → `rd_data` compared cycle k+1.
- Reads per run: 3·DEPTH; err_count width never saturates at legal DEPTH.

## Structure
- Package `ram_bist_pkg`: state enum, element background constants (BG0 = all-zeros, BG1 = all-ones as width-generic fill).
- Sub-module `ram_bist_cmp`: compare pipeline, err_count, first-fail capture; top holds FSM and address counter.
- Bench instantiates the existing RAM plus `ram_bist`; a fault-injecting RAM model is bench-only.

## Test plan
- Clean RAM, DEPTH=16, start at cycle 0 → done at cycle 66, pass=1, err_count=0, fail_addr=0.
- Bit 0 stuck-at-1 at address 5 → M1 and M3 fail at 5: err_count=2, fail_addr=5, pass=0.
- Address 9 bit 7 stuck-at-0 → M2 fails at 9: err_count=1, fail_addr=9; failures at 3 and 12 → fail_addr=12 (M2 descending reaches 12 first), err_count=2.
- Reset asserted at cycle 30 mid-M1 → next cycle busy=0, wr_enb=rd_enb=0; no done; new start completes normally.
- Start pulsed during M2 → ignored, done still at cycle 66; start held high → back-to-back runs, err_count cleared at each start.
- Check every RAM-side address sequence: M2 issues 15..0, wr_addr==rd_addr in M1/M2, wr_enb=0 in M3.
